// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU use shift-add, DIV/DIVU use restoring division; every
// operation takes a fixed 33 edges from start to HI/LO update. MTHI/MTLO
// writes are serviced while idle.
//
// Handshake: start is accepted only while state==IDLE (busy==0). busy rises
// on the accepting edge and falls on the edge that writes HI/LO, which is the
// same edge that raises done for one cycle. Nothing is queued while busy.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // state is kept as a named signal so checkers can bind to it
    state_t             state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   p_hi;
    logic [WIDTH-1:0]   p_lo;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;

    // op[0]==0 selects the signed variants
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // operand magnitudes and sign capture for the accepting edge
    always_comb begin
        a_neg    = ~op[0] & a[WIDTH-1];
        b_neg    = ~op[0] & b[WIDTH-1];
        a_mag_in = a_neg ? (~a + 1'b1) : a;
        b_mag_in = b_neg ? (~b + 1'b1) : b;
    end

    // one iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum   = p_lo[0] ? ({1'b0, p_hi} + {1'b0, mag_a}) : {1'b0, p_hi};
        div_trial = {p_hi, p_lo[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, mag_b});
        div_diff  = div_trial - {1'b0, mag_b};
        if (op_r[1]) begin
            // p_hi holds the partial remainder, p_lo shifts dividend out and quotient in
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {p_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
        end
    end

    // sign correction of the magnitude results
    always_comb begin
        prod_fix = neg_q ? (~{p_hi, p_lo} + 1'b1) : {p_hi, p_lo};
        quo_fix  = neg_q ? (~p_lo + 1'b1) : p_lo;
        rem_fix  = neg_r ? (~p_hi + 1'b1) : p_hi;
    end

    // control FSM, datapath registers and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_r        <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            dividend    <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // start wins over a same-cycle MTHI/MTLO
                        op_r     <= op;
                        mag_a    <= a_mag_in;
                        mag_b    <= b_mag_in;
                        dividend <= a;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        b_zero   <= (b == '0);
                        p_hi     <= '0;
                        p_lo     <= op[1] ? a_mag_in : b_mag_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        if (mthi_we) hi <= mt_data;
                        if (mtlo_we) lo <= mt_data;
                    end
                end
                RUN: begin
                    p_hi <= step_hi;
                    p_lo <= step_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (op_r[1]) begin
                        if (b_zero) begin
                            lo          <= '1;
                            hi          <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo          <= quo_fix;
                            hi          <= rem_fix;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        {hi, lo}    <= prod_fix;
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit owning the architectural HI/LO registers for the MIPS unicycle core.
- Executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle sequence, and services MTHI/MTLO writes.
- Drives hi/lo to the ALU's MFHI/MFLO result path.
- Control stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new mul/div; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- mthi_we  input  1  write mt_data into HI (IDLE only)
- mtlo_we  input  1  write mt_data into LO (IDLE only)
- mt_data  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO updated by an operation
- div_by_zero  output  1  sticky flag: last DIV/DIVU had b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; hi=0; lo=0; busy=0; done=0; div_by_zero=0; counter=0. Applies mid-operation; the operation is abandoned with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: latch op, |a|, |b| (magnitudes for signed ops; raw values for unsigned), and result signs.
  - Clear the partial accumulators, counter=0, go to RUN, busy=1 from after E0.
  - done is 0 in every state except the cycle after the FIX edge.
- RUN: one iteration per edge for exactly WIDTH edges (E1..E32); on the 32nd, go to FIX.
  - Multiply: shift-add, 64-bit product accumulating in {P_hi, P_lo}.
  - Divide: restoring, one quotient bit per edge, MSB first; 33-bit remainder compare/subtract.
- FIX (edge E33):
  - Apply sign correction and write hi/lo.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
  - Latency is a fixed 33 edges from start to HI/LO visible, independent of operand values.
- MULT: {hi,lo} = signed 64-bit product; negate the magnitude product if a[31]^b[31].
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - -2^31 / -1: lo=0x80000000, hi=0; no trap, no flag.
- DIVU: unsigned quotient/remainder.
- Divide by zero (DIV or DIVU with b==0):
  - Full latency is still taken.
  - lo=0xFFFFFFFF, hi=a (original dividend).
  - div_by_zero=1 at FIX.
- div_by_zero is cleared at the FIX edge of any subsequent op whose divisor is nonzero, and for MULT/MULTU.
- start while busy: ignored; no queuing.
- MTHI/MTLO:
  - In IDLE, mthi_we writes hi and mtlo_we writes lo on the next edge; both may assert together.
  - Ignored while busy, including in the FIX cycle.
  - start and mt*_we in the same IDLE cycle: start wins, the mt write is dropped.
- Operands a/b may change after E0 without affecting the result.
- hi/lo hold their previous values for the whole RUN period.

Test Plan:
- rst, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles, done pulse at edge 33, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB (-21); done exactly one cycle.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=100 div_by_zero=1; following DIVU 100/7 -> lo=14 hi=2 div_by_zero=0.
- MTHI 0x1234 and MTLO 0x5678 in the same IDLE cycle -> hi=0x1234 lo=0x5678 next edge. start a second op and mtlo_we while busy -> both ignored. start+mthi_we together in IDLE -> only the op executes.
- Assert rst at RUN iteration 10 of a MULT -> next edge hi=lo=0, busy=0, done never pulses. A new start afterwards completes normally in 33 edges.
